// File: rtl/delay_pkg.sv
// Shared definitions for the delay-chain sweep controller: FSM state encoding
// and the width helpers used to size tap, result and counter fields.
package delay_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    LAUNCH,
    CAPTURE,
    NEXT,
    DONE
  } state_t;

  // Bits needed to index n items (0..n-1); never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a count or result in 0..n inclusive.
  function automatic int res_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/delay_sweep_lane.sv
// One measurement lane: capture flop on the selected tap, saturating failure
// counter for the current tap, and the first-failing-tap result register.
module delay_sweep_lane
  import delay_pkg::*;
#(
  parameter int TAPS   = 9,
  parameter int REPEAT = 3,
  localparam int TW    = idx_w(TAPS),
  localparam int RW    = res_w(TAPS),
  localparam int FW    = res_w(REPEAT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_all,
  input  logic            clear_cnt,
  input  logic            capture,
  input  logic            count,
  input  logic            commit,
  input  logic [TW-1:0]   tap,
  input  logic [TAPS-1:0] tap_q,
  output logic [RW-1:0]   first_fail,
  output logic [FW-1:0]   fail_cnt,
  output logic            failed
);

  localparam logic [RW-1:0] NONE = RW'(TAPS);

  logic cap;

  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
    return (v >= FW'(REPEAT)) ? v : v + FW'(1);
  endfunction

  // Sampled at the edge leaving LAUNCH: exactly one period after the launch edge.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap <= tap_q[tap];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_fail <= NONE;
      fail_cnt   <= '0;
    end else if (clear_all) begin
      first_fail <= NONE;
      fail_cnt   <= '0;
    end else begin
      if (count && !cap) begin
        fail_cnt <= sat_inc(fail_cnt);
      end
      if (commit) begin
        if ((fail_cnt != '0) && (first_fail == NONE)) begin
          first_fail <= RW'(tap);
        end
        if (clear_cnt) begin
          fail_cnt <= '0;
        end
      end
    end
  end

  // Looks ahead through the pending commit so the sweep can stop in the same NEXT cycle.
  assign failed = (first_fail != NONE) || (fail_cnt != '0);

endmodule

// File: rtl/delay_sweep_ctrl.sv
// Self-timed launch/capture sweep controller for tapped delay-chain
// characterisation: FSM, settle/trial/tap counters, launch register, lanes.
module delay_sweep_ctrl
  import delay_pkg::*;
#(
  parameter int CH     = 8,
  parameter int TAPS   = 9,
  parameter int REPEAT = 3,
  parameter int SETTLE = 4,
  localparam int TW    = idx_w(TAPS),
  localparam int RW    = res_w(TAPS),
  localparam int FW    = res_w(REPEAT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [TW-1:0]      tap_idx,
  output logic [CH-1:0]      launch,
  input  logic [CH*TAPS-1:0] tap_q,
  output logic               busy,
  output logic               done,
  output logic [CH*RW-1:0]   first_fail,
  output logic [CH*FW-1:0]   fail_cnt
);

  localparam int SW = idx_w(SETTLE);
  localparam int QW = idx_w(REPEAT);

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   settle_cnt;
  logic [QW-1:0]   trial_cnt;
  logic [TW-1:0]   tap;
  logic [TW-1:0]   start_tap;
  logic            mode_r;
  logic [CH-1:0]   launch_r;
  logic [CH-1:0]   lane_failed;
  logic            clear_all;
  logic            clear_cnt;
  logic            capture;
  logic            count;
  logic            commit;
  logic            finish;

  assign start_tap = (int'(tap_idx) >= TAPS) ? TW'(TAPS - 1) : tap_idx;
  assign finish    = !mode_r || (tap == TW'(TAPS - 1)) || (&lane_failed);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clear_all = 1'b0;
    clear_cnt = 1'b0;
    capture   = 1'b0;
    count     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_all = 1'b1;
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        if (settle_cnt == SW'(SETTLE - 1)) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        capture   = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        count     = 1'b1;
        state_nxt = (trial_cnt == QW'(REPEAT - 1)) ? NEXT : PRIME;
      end
      NEXT: begin
        commit    = 1'b1;
        clear_cnt = !finish;
        state_nxt = finish ? DONE : PRIME;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Launch is registered so the chain sees a clean flop edge aligned to the capture clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      launch_r   <= '0;
      settle_cnt <= '0;
      trial_cnt  <= '0;
      tap        <= '0;
      mode_r     <= 1'b0;
    end else begin
      launch_r   <= {CH{state_nxt == LAUNCH}};
      settle_cnt <= (state == PRIME) ? settle_cnt + SW'(1) : '0;
      if (clear_all) begin
        mode_r    <= mode;
        tap       <= mode ? '0 : start_tap;
        trial_cnt <= '0;
      end else if (count) begin
        trial_cnt <= trial_cnt + QW'(1);
      end else if (clear_cnt) begin
        tap       <= tap + TW'(1);
        trial_cnt <= '0;
      end
    end
  end

  assign launch = launch_r;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  for (genvar c = 0; c < CH; c++) begin : g_lane
    delay_sweep_lane #(
      .TAPS   (TAPS),
      .REPEAT (REPEAT)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_all  (clear_all),
      .clear_cnt  (clear_cnt),
      .capture    (capture),
      .count      (count),
      .commit     (commit),
      .tap        (tap),
      .tap_q      (tap_q[c*TAPS +: TAPS]),
      .first_fail (first_fail[c*RW +: RW]),
      .fail_cnt   (fail_cnt[c*FW +: FW]),
      .failed     (lane_failed[c])
    );
  end

endmodule
